// File: rtl/tetris_round_ctrl.sv
// rtl/tetris_round_ctrl.sv - round sequencer between the host piece stream and the TETRIS core
// Issues one piece at a time, tracks the round and reports a summary or an error strobe.
module tetris_round_ctrl #(
    parameter int PIECES_PER_ROUND = 16,
    parameter int TIMEOUT          = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [2:0] host_tetromino,
    input  logic [2:0] host_position,
    output logic       core_in_valid,
    output logic [2:0] core_tetrominoes,
    output logic [2:0] core_position,
    input  logic       core_score_valid,
    input  logic       core_fail,
    input  logic       core_tetris_valid,
    input  logic [3:0] core_score,
    output logic       done_valid,
    output logic       done_fail,
    output logic [4:0] done_pieces,
    output logic [3:0] done_score,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [4:0] LAST_PIECE = 5'(PIECES_PER_ROUND);
    localparam logic [7:0] TIMER_LIM  = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [4:0] cnt;
    logic [7:0] timer;
    logic       accept;
    logic       last_piece;

    assign accept     = host_valid && host_ready;
    assign last_piece = (cnt == LAST_PIECE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A result in the last timer cycle takes priority over the timeout.
                if (core_score_valid) begin
                    if (core_fail) begin
                        state_nx = S_DONE;
                    end else if (last_piece) begin
                        state_nx = core_tetris_valid ? S_DONE : S_ERR;
                    end else begin
                        state_nx = core_tetris_valid ? S_ERR : S_IDLE;
                    end
                end else if (timer == TIMER_LIM) begin
                    state_nx = S_ERR;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            S_ERR: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            host_ready    <= 1'b0;
            core_in_valid <= 1'b0;
            done_valid    <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nx;
            host_ready    <= (state_nx == S_IDLE);
            core_in_valid <= (state_nx == S_ISSUE);
            done_valid    <= (state_nx == S_DONE);
            err           <= (state_nx == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_tetrominoes <= 3'd0;
            core_position    <= 3'd0;
        end else if (state == S_IDLE && accept) begin
            core_tetrominoes <= host_tetromino;
            core_position    <= host_position;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= 8'd0;
            cnt   <= 5'd0;
        end else begin
            case (state)
                S_ISSUE: begin
                    timer <= 8'd0;
                    cnt   <= cnt + 5'd1;
                end
                S_WAIT: begin
                    timer <= timer + 8'd1;
                end
                S_DONE, S_ERR: begin
                    cnt <= 5'd0;
                end
                default: begin
                    timer <= timer;
                end
            endcase
        end
    end

    // Summary fields are loaded only when a round ends, so they hold until the next summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_fail   <= 1'b0;
            done_pieces <= 5'd0;
            done_score  <= 4'd0;
        end else if (state == S_WAIT && state_nx == S_DONE) begin
            done_fail   <= core_fail;
            done_pieces <= cnt;
            done_score  <= core_score;
        end
    end

endmodule

// File: tb/tb_tetris_round_ctrl.sv
// tb/tb_tetris_round_ctrl.sv - scoreboard bench for tetris_round_ctrl
module tb_tetris_round_ctrl;

    localparam int PPR = 16;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [2:0] host_tetromino = 3'd0;
    logic [2:0] host_position = 3'd0;
    logic       core_in_valid;
    logic [2:0] core_tetrominoes;
    logic [2:0] core_position;
    logic       core_score_valid = 1'b0;
    logic       core_fail = 1'b0;
    logic       core_tetris_valid = 1'b0;
    logic [3:0] core_score = 4'd0;
    logic       done_valid;
    logic       done_fail;
    logic [4:0] done_pieces;
    logic [3:0] done_score;
    logic       err;

    tetris_round_ctrl #(.PIECES_PER_ROUND(PPR), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_tetromino(host_tetromino), .host_position(host_position),
        .core_in_valid(core_in_valid), .core_tetrominoes(core_tetrominoes),
        .core_position(core_position), .core_score_valid(core_score_valid),
        .core_fail(core_fail), .core_tetris_valid(core_tetris_valid),
        .core_score(core_score), .done_valid(done_valid), .done_fail(done_fail),
        .done_pieces(done_pieces), .done_score(done_score), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        bit fail;
        int pieces;
        int score;
        int cycle;
    } ev_t;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int model_cnt = 0;
    ev_t exp_ev[$];
    logic [5:0] exp_pc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_in_valid) begin
                pulse_cnt++;
                if (exp_pc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_in_valid actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    logic [5:0] pc;
                    pc = exp_pc.pop_front();
                    chk("core_tetrominoes", core_tetrominoes, pc[5:3]);
                    chk("core_position", core_position, pc[2:0]);
                end
            end
            if (done_valid || err) begin
                if (exp_ev.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual done=%0b err=%0b required none (cycle %0d)",
                             done_valid, err, cyc);
                end else begin
                    ev_t e;
                    e = exp_ev.pop_front();
                    chk("event_is_err", err, e.is_err);
                    chk("event_is_done", done_valid, !e.is_err);
                    chk("event_cycle", cyc, e.cycle);
                    if (!e.is_err) begin
                        chk("done_fail", done_fail, e.fail);
                        chk("done_pieces", done_pieces, e.pieces);
                        chk("done_score", done_score, e.score);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_host_ready", host_ready, 0);
        chk("rst_core_in_valid", core_in_valid, 0);
        chk("rst_core_tetrominoes", core_tetrominoes, 0);
        chk("rst_core_position", core_position, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_fail", done_fail, 0);
        chk("rst_done_pieces", done_pieces, 0);
        chk("rst_done_score", done_score, 0);
        chk("rst_err", err, 0);
    endtask

    // mode: 0 core answers after j WAIT cycles, 1 core silent, 2 reset pulsed during WAIT.
    // outc: 0 round continues, 1 round summary, 2 error.
    task automatic run_piece(input logic [2:0] t, input logic [2:0] p, input bit hold,
                             input int j, input bit f, input bit tv, input logic [3:0] sc,
                             input int mode, output int outc);
        int n;
        int k;
        int m;
        bit final_piece;
        ev_t e;
        outc = 0;
        host_tetromino = t;
        host_position = p;
        host_valid = 1'b1;
        n = 0;
        while (!host_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", host_ready, 1);
        if (!host_ready) begin
            host_valid = 1'b0;
            outc = 2;
            return;
        end
        @(posedge clk); #1;
        k = cyc;
        exp_pc.push_back({t, p});
        model_cnt++;
        if (!hold) host_valid = 1'b0;
        chk("issue_strobe", core_in_valid, 1);
        chk("ready_low_issue", host_ready, 0);
        if (mode == 1) begin
            e = '{is_err: 1'b1, fail: 1'b0, pieces: 0, score: 0, cycle: k + 1 + TMO};
            exp_ev.push_back(e);
            model_cnt = 0;
            repeat (1 + TMO) @(posedge clk);
            #1;
            @(posedge clk); #1;
            chk("ready_after_timeout", host_ready, 1);
            outc = 2;
            return;
        end
        if (mode == 2) begin
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check_reset_vals();
            model_cnt = 0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            chk("ready_low_after_release", host_ready, 0);
            @(posedge clk); #1;
            chk("ready_first_edge", host_ready, 1);
            outc = 2;
            return;
        end
        repeat (j) @(posedge clk);
        #1;
        chk("ready_low_wait", host_ready, 0);
        core_score_valid = 1'b1;
        core_fail = f;
        core_tetris_valid = tv;
        core_score = sc;
        m = k + 1 + j;
        final_piece = (model_cnt == PPR);
        if (f) begin
            outc = 1;
        end else if (final_piece) begin
            outc = tv ? 1 : 2;
        end else begin
            outc = tv ? 2 : 0;
        end
        if (outc != 0) begin
            e = '{is_err: (outc == 2), fail: f, pieces: model_cnt, score: sc, cycle: m};
            exp_ev.push_back(e);
            model_cnt = 0;
        end
        @(posedge clk); #1;
        core_score_valid = 1'b0;
        core_fail = 1'b0;
        core_tetris_valid = 1'b0;
        core_score = 4'($urandom_range(0, 15));
        if (outc == 0) begin
            chk("ready_continue", host_ready, 1);
        end else begin
            chk("ready_low_end", host_ready, 0);
            @(posedge clk); #1;
            chk("ready_back", host_ready, 1);
        end
    endtask

    task automatic plain_piece(input int j, output int outc);
        run_piece(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, j, 1'b0, 1'b0,
                  4'($urandom_range(0, 15)), 0, outc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int outc;
        int base;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        chk("ready_before_first_edge", host_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_first_edge", host_ready, 1);

        // Full round, 2-cycle core, final score 3.
        base = pulse_cnt;
        for (int i = 1; i <= PPR; i++) begin
            run_piece(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 2, 1'b0,
                      (i == PPR), (i == PPR) ? 4'd3 : 4'((i * 3) / PPR), 0, outc);
        end
        chk("full_round_pulses", pulse_cnt - base, PPR);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done_pieces", done_pieces, PPR);
        chk("hold_done_score", done_score, 3);
        chk("hold_done_fail", done_fail, 0);

        // Fail on the 5th piece, then a new round that fails on its first piece.
        for (int i = 1; i <= 4; i++) plain_piece(1, outc);
        run_piece(3'd2, 3'd5, 1'b0, 1, 1'b1, 1'b0, 4'd1, 0, outc);
        run_piece(3'd6, 3'd1, 1'b0, 3, 1'b1, 1'b0, 4'd2, 0, outc);

        // Host keeps valid asserted for a whole round.
        for (int i = 1; i <= PPR; i++) begin
            run_piece(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1,
                      $urandom_range(1, 3), 1'b0, (i == PPR), 4'($urandom_range(0, 15)), 0, outc);
        end
        host_valid = 1'b0;

        // Silent core, then a result exactly at the timeout boundary.
        plain_piece(1, outc);
        run_piece(3'd1, 3'd1, 1'b0, 1, 1'b0, 1'b0, 4'd0, 1, outc);
        plain_piece(TMO, outc);

        // Spurious result in IDLE is ignored.
        core_score_valid = 1'b1;
        core_fail = 1'b1;
        core_tetris_valid = 1'b1;
        @(posedge clk); #1;
        core_score_valid = 1'b0;
        core_fail = 1'b0;
        core_tetris_valid = 1'b0;
        chk("spurious_ready", host_ready, 1);
        chk("spurious_in_valid", core_in_valid, 0);

        // Final piece without tetris_valid is an error.
        while (model_cnt < PPR - 1) plain_piece(1, outc);
        run_piece(3'd4, 3'd3, 1'b0, 2, 1'b0, 1'b0, 4'd9, 0, outc);

        // Reset during WAIT of piece 7, then a fresh full round.
        for (int i = 1; i <= 6; i++) plain_piece(2, outc);
        run_piece(3'd7, 3'd7, 1'b0, 1, 1'b0, 1'b0, 4'd0, 2, outc);
        for (int i = 1; i <= PPR; i++) begin
            run_piece(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 1, 1'b0,
                      (i == PPR), 4'd5, 0, outc);
        end

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            outc = 0;
            for (int i = 0; i < PPR + 2 && outc == 0; i++) begin
                bit f;
                bit tv;
                int mode;
                f = ($urandom_range(0, 15) == 0);
                if (model_cnt + 1 == PPR) tv = ($urandom_range(0, 9) != 0);
                else tv = ($urandom_range(0, 19) == 0);
                mode = ($urandom_range(0, 39) == 0) ? 1 : 0;
                run_piece(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), hold,
                          $urandom_range(1, TMO), f, tv, 4'($urandom_range(0, 15)), mode, outc);
            end
            host_valid = 1'b0;
        end

        repeat (5) @(posedge clk);
        #1;
        chk("events_drained", exp_ev.size(), 0);
        chk("pieces_drained", exp_pc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tetris_round_ctrl.md
# tetris_round_ctrl

Round sequencer between the host piece stream and the `TETRIS` core. It accepts one piece at a time from the host over a valid/ready handshake and issues it to the core as a single-cycle `in_valid` pulse. It waits for the core's result, counts pieces per round and ends the round on `fail` or on the last piece. It reports a per-round summary and aborts a round if the core stops responding.

## Interface
- `PIECES_PER_ROUND`, 16: pieces in a full round (2..31).
- `TIMEOUT`, 255: maximum cycles in WAIT without `core_score_valid` (1..255).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `host_valid`  in  1  host piece available.
- `host_ready`  out  1  controller can accept a piece (registered).
- `host_tetromino`  in  3  piece type.
- `host_position`  in  3  drop column.
- `core_in_valid`  out  1  one-cycle piece strobe to core.
- `core_tetrominoes`  out  3  piece type to core; held stable from ISSUE until next accept.
- `core_position`  out  3  column to core; held stable with `core_tetrominoes`.
- `core_score_valid`  in  1  core result strobe.
- `core_fail`  in  1  core overflow flag, sampled with `core_score_valid`.
- `core_tetris_valid`  in  1  core board-valid flag, sampled with `core_score_valid`.
- `core_score`  in  4  core cumulative round score, sampled with `core_score_valid`.
- `done_valid`  out  1  one-cycle round-summary strobe.
- `done_fail`  out  1  round ended by fail.
- `done_pieces`  out  5  pieces issued in the round (1..PIECES_PER_ROUND).
- `done_score`  out  4  last `core_score` of the round.
- `err`  out  1  one-cycle protocol or timeout error strobe.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR. Reset state is IDLE.
- IDLE:
  - `host_ready`=1.
  - On `host_valid && host_ready`, latch tetromino and position into the core-side registers, then go to ISSUE.
- ISSUE:
  - `core_in_valid`=1 for exactly this cycle.
  - Clear the wait timer, increment the piece count `cnt`, go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - On `core_score_valid`, latch `core_score` and `core_fail`.
    - If `core_fail` or `cnt==PIECES_PER_ROUND`, go to DONE.
    - Otherwise go to IDLE.
  - On the final piece (`cnt==PIECES_PER_ROUND`, no fail), `core_tetris_valid` must be 1. If it is 0, go to ERR.
  - `core_tetris_valid`=1 on a non-final, non-fail result is also a protocol error and goes to ERR.
  - If the timer reaches TIMEOUT without `core_score_valid`, go to ERR.
- DONE:
  - `done_valid`=1 for one cycle.
  - `done_fail`, `done_pieces`=`cnt` and `done_score` are valid in that cycle and hold until the next DONE.
  - Clear `cnt`, go to IDLE.
- ERR:
  - `err`=1 for one cycle.
  - Clear `cnt` (round aborted, no `done_valid`), go to IDLE.
- `core_score_valid` outside WAIT is ignored and causes no state change.
- `host_ready`=0 in every state except IDLE; host data is never dropped or duplicated.

## Timing
- Reset values: `host_ready`=0, `core_in_valid`=0, `core_tetrominoes`=0, `core_position`=0, `done_valid`=0, `done_fail`=0, `done_pieces`=0, `done_score`=0, `err`=0, `cnt`=0.
- `host_ready` rises on the first clock edge after `rst_n` deasserts.
- Accept at edge k gives `core_in_valid` high in cycle k+1 (latency 1).
- `core_score_valid` sampled at edge m:
  - `host_ready`=1 in cycle m+1 when the round continues.
  - `done_valid`=1 in cycle m+1 when the round ends; `host_ready` returns in m+2.
- Best-case throughput: one piece per 3 cycles with a 1-cycle core (IDLE, ISSUE, WAIT).
- Timeout and `core_score_valid` in the same cycle: the result wins, no `err`.
- `core_fail` together with the final piece: `done_fail`=1 and `done_pieces`=PIECES_PER_ROUND.
- `rst_n` asserted mid-round: immediate return to reset values; the partial round is discarded with no `done_valid`.

## Test plan
- Full round, 16 pieces, core responds 2 cycles after each `in_valid`, never fails, final `core_score`=3 with `core_tetris_valid`=1:
  - exactly 16 `core_in_valid` pulses;
  - one `done_valid` with `done_fail`=0, `done_pieces`=16, `done_score`=3.
- Fail on 5th piece, `core_score`=1: `done_valid` one cycle after that result with `done_fail`=1, `done_pieces`=5, `done_score`=1. The next host piece starts a new round (`cnt` restarts at 1).
- Host backpressure: `host_valid` held high continuously → each piece accepted once and `host_ready` low from ISSUE through the result. `core_tetrominoes`/`core_position` match the host sequence in order.
- Core silent after a piece, TIMEOUT=8 → `err` pulse exactly 8 cycles into WAIT, no `done_valid`, `host_ready`=1 the cycle after.
- Spurious results: `core_score_valid` in IDLE is ignored. Final piece answered with `core_tetris_valid`=0 → `err`, no `done_valid`.
- `rst_n` pulsed low during WAIT of piece 7 → all outputs at reset values. After release, a fresh 16-piece round completes with `done_pieces`=16.
